// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port (CPU/chipset) arbiter in front of an SRAM-like DDR3 wrapper
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] a_Addr,
  input  logic                  a_CS,
  input  logic                  a_L,
  input  logic                  a_U,
  input  logic                  a_WE,
  input  logic [15:0]           a_WR,
  output logic [15:0]           a_RD,
  output logic                  a_ready,
  output logic                  a_busy,
  input  logic [ADDR_WIDTH-1:0] b_Addr,
  input  logic                  b_CS,
  input  logic                  b_L,
  input  logic                  b_U,
  input  logic                  b_WE,
  input  logic [15:0]           b_WR,
  output logic [15:0]           b_RD,
  output logic                  b_ready,
  output logic                  b_busy,
  output logic [ADDR_WIDTH-1:0] m_Addr,
  output logic                  m_CS,
  output logic                  m_L,
  output logic                  m_U,
  output logic                  m_WE,
  output logic [15:0]           m_WR,
  input  logic [15:0]           m_RD,
  input  logic                  m_ready,
  input  logic                  m_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  l;
    logic                  u;
    logic                  we;
    logic [15:0]           wr;
  } req_t;

  typedef struct packed {
    logic cs;
    req_t r;
  } mreq_t;

  state_t state, next_state;
  req_t   req_a, req_b, sel_req;
  mreq_t  m_q, m_nxt;
  logic   pend_a, pend_b;
  logic   last_b, grant_b, pick_b;
  logic   issue, done, done_a, done_b;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  // On a tie B wins only in round-robin mode and only if A was granted last.
  always_comb begin
    pick_b     = pend_b && (!pend_a || (FIXED_PRIO == 0 && !last_b));
    next_state = state;
    case (state)
      IDLE:      if ((pend_a || pend_b) && !m_busy) next_state = ISSUE;
      ISSUE:     if (m_busy)  next_state = WAIT_DONE;
      WAIT_DONE: if (m_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    sel_req = pick_b ? req_b : req_a;
    issue   = (state == IDLE) && (next_state == ISSUE);
    done    = (state == WAIT_DONE) && m_ready;
    m_nxt   = '0;
    if (issue) begin
      m_nxt.cs = 1'b1;
      m_nxt.r  = sel_req;
    end else if (state == ISSUE && !m_busy) begin
      m_nxt = m_q;
    end
  end

  assign done_a = done && !grant_b;
  assign done_b = done && grant_b;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      req_a   <= '0;
      req_b   <= '0;
      last_b  <= 1'b1;
      grant_b <= 1'b0;
      m_q     <= '0;
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      a_RD    <= 16'h0;
      b_RD    <= 16'h0;
    end else begin
      a_ready <= done_a;
      b_ready <= done_b;
      m_q     <= m_nxt;
      if (a_CS && !pend_a) begin
        pend_a <= 1'b1;
        req_a  <= '{addr: a_Addr, l: a_L, u: a_U, we: a_WE, wr: a_WR};
      end
      if (b_CS && !pend_b) begin
        pend_b <= 1'b1;
        req_b  <= '{addr: b_Addr, l: b_L, u: b_U, we: b_WE, wr: b_WR};
      end
      if (done_a) begin
        pend_a <= 1'b0;
        if (!req_a.we) a_RD <= m_RD;
      end
      if (done_b) begin
        pend_b <= 1'b0;
        if (!req_b.we) b_RD <= m_RD;
      end
      if (issue) begin
        grant_b <= pick_b;
        last_b  <= pick_b;
      end
    end
  end

  assign a_busy = pend_a;
  assign b_busy = pend_b;
  assign m_CS   = m_q.cs;
  assign m_Addr = m_q.r.addr;
  assign m_L    = m_q.r.l;
  assign m_U    = m_q.r.u;
  assign m_WE   = m_q.r.we;
  assign m_WR   = m_q.r.wr;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed bench for sram_port_arbiter (round-robin and fixed-priority builds)
module tb_sram_port_arbiter;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [15:0]   a_wr = '0, b_wr = '0;
  logic          a_cs = 0, a_l = 0, a_u = 0, a_we = 0;
  logic          b_cs = 0, b_l = 0, b_u = 0, b_we = 0;
  logic          sel_fp = 0, model_en = 1, man_busy = 0, man_ready = 0;
  logic          mdl_busy = 0, mdl_ready = 0;
  logic [15:0]   m_rd = '0;

  logic [AW-1:0] r_m_addr, f_m_addr;
  logic [15:0]   r_a_rd, r_b_rd, r_m_wr, f_a_rd, f_b_rd, f_m_wr;
  logic r_a_ready, r_a_busy, r_b_ready, r_b_busy, r_m_cs, r_m_l, r_m_u, r_m_we;
  logic f_a_ready, f_a_busy, f_b_ready, f_b_busy, f_m_cs, f_m_l, f_m_u, f_m_we;

  wire bus_busy  = model_en ? mdl_busy : man_busy;
  wire bus_ready = model_en ? mdl_ready : man_ready;
  wire a_cs_r = a_cs && !sel_fp, b_cs_r = b_cs && !sel_fp;
  wire a_cs_f = a_cs && sel_fp,  b_cs_f = b_cs && sel_fp;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .i_rst(rst),
    .a_Addr(a_addr), .a_CS(a_cs_r), .a_L(a_l), .a_U(a_u), .a_WE(a_we), .a_WR(a_wr),
    .a_RD(r_a_rd), .a_ready(r_a_ready), .a_busy(r_a_busy),
    .b_Addr(b_addr), .b_CS(b_cs_r), .b_L(b_l), .b_U(b_u), .b_WE(b_we), .b_WR(b_wr),
    .b_RD(r_b_rd), .b_ready(r_b_ready), .b_busy(r_b_busy),
    .m_Addr(r_m_addr), .m_CS(r_m_cs), .m_L(r_m_l), .m_U(r_m_u), .m_WE(r_m_we), .m_WR(r_m_wr),
    .m_RD(m_rd), .m_ready(sel_fp ? 1'b0 : bus_ready), .m_busy(sel_fp ? 1'b1 : bus_busy)
  );

  sram_port_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .i_rst(rst),
    .a_Addr(a_addr), .a_CS(a_cs_f), .a_L(a_l), .a_U(a_u), .a_WE(a_we), .a_WR(a_wr),
    .a_RD(f_a_rd), .a_ready(f_a_ready), .a_busy(f_a_busy),
    .b_Addr(b_addr), .b_CS(b_cs_f), .b_L(b_l), .b_U(b_u), .b_WE(b_we), .b_WR(b_wr),
    .b_RD(f_b_rd), .b_ready(f_b_ready), .b_busy(f_b_busy),
    .m_Addr(f_m_addr), .m_CS(f_m_cs), .m_L(f_m_l), .m_U(f_m_u), .m_WE(f_m_we), .m_WR(f_m_wr),
    .m_RD(m_rd), .m_ready(sel_fp ? bus_ready : 1'b0), .m_busy(sel_fp ? bus_busy : 1'b1)
  );

  wire [AW-1:0] s_m_addr = sel_fp ? f_m_addr : r_m_addr;
  wire [15:0]   s_m_wr   = sel_fp ? f_m_wr : r_m_wr;
  wire [15:0]   s_a_rd   = sel_fp ? f_a_rd : r_a_rd;
  wire [15:0]   s_b_rd   = sel_fp ? f_b_rd : r_b_rd;
  wire s_m_cs    = sel_fp ? f_m_cs : r_m_cs;
  wire s_m_l     = sel_fp ? f_m_l : r_m_l;
  wire s_m_u     = sel_fp ? f_m_u : r_m_u;
  wire s_m_we    = sel_fp ? f_m_we : r_m_we;
  wire s_a_ready = sel_fp ? f_a_ready : r_a_ready;
  wire s_b_ready = sel_fp ? f_b_ready : r_b_ready;
  wire s_a_busy  = sel_fp ? f_a_busy : r_a_busy;
  wire s_b_busy  = sel_fp ? f_b_busy : r_b_busy;

  // Wrapper model: busy 2 cycles after m_CS is seen, ready pulse 5 cycles after.
  logic [15:0] mem [16];
  int  mcnt = 0;
  bit  mact = 0;
  initial for (int i = 0; i < 16; i++) mem[i] = 16'h0;
  always @(negedge clk) begin
    mdl_ready = 1'b0;
    if (!model_en || rst) begin
      mact = 0; mcnt = 0; mdl_busy = 1'b0;
    end else if (mact) begin
      mcnt++;
      if (mcnt == 2) mdl_busy = 1'b1;
      if (mcnt == 5) begin mdl_busy = 1'b0; mdl_ready = 1'b1; mact = 0; end
    end else if (s_m_cs) begin
      mact = 1; mcnt = 0;
      if (s_m_we) mem[s_m_addr[3:0]] = s_m_wr;
      else        m_rd = mem[s_m_addr[3:0]];
    end
  end

  // Grant log, ready-pulse counts and a single-outstanding watchdog.
  logic [AW-1:0] gq[$];
  int  na = 0, nb = 0, outst = 0;
  bit  prev_cs = 0, overlap = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_cs = 0; outst = 0;
    end else begin
      if (s_m_cs && !prev_cs) begin
        gq.push_back(s_m_addr);
        outst++;
        if (outst > 1) overlap = 1;
      end
      if (s_a_ready) begin na++; outst--; end
      if (s_b_ready) begin nb++; outst--; end
      prev_cs = s_m_cs;
    end
  end

  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_a(input logic [AW-1:0] ad, input logic [15:0] d, input logic we);
    a_addr = ad; a_wr = d; a_we = we; a_l = 1; a_u = 1; a_cs = 1;
  endtask

  task automatic start_b(input logic [AW-1:0] ad, input logic [15:0] d, input logic we);
    b_addr = ad; b_wr = d; b_we = we; b_l = 1; b_u = 1; b_cs = 1;
  endtask

  task automatic wait_rdy(input bit pb, input int lim, output int n);
    n = 0;
    while (n < lim) begin
      tick();
      n++;
      if (pb ? s_b_ready : s_a_ready) return;
    end
    n = -1;
  endtask

  int n, q0, na0, nb0;
  logic [AW-1:0] exp_a;

  initial begin
    repeat (3) tick();
    check("rst_flags", {s_m_cs, s_m_l, s_m_u, s_m_we, s_a_ready, s_b_ready, s_a_busy, s_b_busy}, 0);
    check("rst_maddr", s_m_addr, 0);
    rst = 0;
    tick();

    start_a(16'h0100, 16'hBEEF, 1); tick(); a_cs = 0;
    check("t1_busy", s_a_busy, 1);
    check("t1_cs_early", s_m_cs, 0);
    tick();
    check("t1_cs", s_m_cs, 1);
    check("t1_addr", s_m_addr, 16'h0100);
    check("t1_wr", s_m_wr, 16'hBEEF);
    check("t1_we", s_m_we, 1);
    wait_rdy(0, 40, n);
    check("t1_latency", n, 6);
    check("t1_rd_kept", s_a_rd, 0);
    check("t1_busy_lo", s_a_busy, 0);
    tick();
    check("t1_one_pulse", s_a_ready, 0);

    start_a(16'h0100, 16'h0, 0); tick(); a_cs = 0;
    wait_rdy(0, 40, n);
    check("t2_done", n > 0, 1);
    check("t2_rd", s_a_rd, 16'hBEEF);
    check("t2_busy_lo", s_a_busy, 0);

    rst = 1; tick(); rst = 0; tick();
    q0 = gq.size(); na0 = na; nb0 = nb;
    for (int r = 0; r < 3; r++) begin
      start_a(16'h0200 + r[15:0], 16'h1000 + r[15:0], 1);
      start_b(16'h0300 + r[15:0], 16'h2000 + r[15:0], 1);
      tick(); a_cs = 0; b_cs = 0;
      wait_rdy(0, 40, n);
      check("t3_a_done", n > 0, 1);
      check("t3_b_waits", s_b_busy, 1);
      wait_rdy(1, 40, n);
      check("t3_b_done", n > 0, 1);
    end
    tick();
    check("t3_ngrant", gq.size() - q0, 6);
    for (int i = 0; i < 6; i++) begin
      exp_a = ((i % 2) ? 16'h0300 : 16'h0200) + 16'(i / 2);
      if (gq.size() > q0 + i) check("t3_order", gq[q0 + i], exp_a);
    end
    check("t3_a_pulses", na - na0, 3);
    check("t3_b_pulses", nb - nb0, 3);
    check("t3_overlap", overlap, 0);

    sel_fp = 1; rst = 1; tick(); rst = 0; tick();
    q0 = gq.size();
    start_a(16'h0400, 16'h00A0, 1); tick(); a_cs = 0;
    wait_rdy(0, 40, n);
    check("t4_a0_done", n > 0, 1);
    model_en = 0; man_busy = 1;
    start_b(16'h0500, 16'h00B0, 1); tick(); b_cs = 0;
    start_a(16'h0401, 16'h00A1, 1); tick(); a_cs = 0;
    tick();
    check("t4_hold", s_m_cs, 0);
    man_busy = 0; model_en = 1;
    tick();
    check("t4_a_wins", s_m_addr, 16'h0401);
    wait_rdy(0, 40, n);
    check("t4_a1_done", n > 0, 1);
    start_a(16'h0402, 16'h00A2, 1); tick(); a_cs = 0;
    check("t4_b_when_a_idle", s_m_addr, 16'h0500);
    wait_rdy(1, 40, n);
    check("t4_b_done", n > 0, 1);
    wait_rdy(0, 40, n);
    check("t4_a2_done", n > 0, 1);
    check("t4_ngrant", gq.size() - q0, 4);
    if (gq.size() == q0 + 4) begin
      check("t4_g0", gq[q0], 16'h0400);
      check("t4_g1", gq[q0 + 1], 16'h0401);
      check("t4_g2", gq[q0 + 2], 16'h0500);
      check("t4_g3", gq[q0 + 3], 16'h0402);
    end

    sel_fp = 0; model_en = 0; man_busy = 1; rst = 1; tick(); rst = 0; tick();
    start_a(16'h0108, 16'h5A5A, 1); tick(); a_cs = 0;
    repeat (3) tick();
    check("t5_cal_hold", s_m_cs, 0);
    check("t5_pending", s_a_busy, 1);
    man_busy = 0; model_en = 1;
    tick();
    check("t5_issue", s_m_cs, 1);
    wait_rdy(0, 40, n);
    check("t5_done", n > 0, 1);

    start_a(16'h0108, 16'h0, 0); tick(); a_cs = 0;
    wait_rdy(0, 40, n);
    check("t6_rd_before", s_a_rd, 16'h5A5A);
    start_a(16'h0100, 16'h0, 0); tick(); a_cs = 0;
    tick();
    check("t6_cs", s_m_cs, 1);
    repeat (3) tick();
    check("t6_wait_done", s_m_cs, 0);
    na0 = na;
    model_en = 0; rst = 1;
    #1;
    check("t6_rst_flags", {s_m_cs, s_m_we, s_a_ready, s_b_ready, s_a_busy, s_b_busy}, 0);
    check("t6_rst_rd", {s_a_rd, s_b_rd}, 0);
    tick(); rst = 0; tick();
    man_ready = 1; tick(); man_ready = 0;
    repeat (4) tick();
    check("t6_no_ready", na - na0, 0);
    check("t6_idle", {s_a_busy, s_m_cs}, 0);
    model_en = 1;
    start_a(16'h010C, 16'h7E7E, 1); tick(); a_cs = 0;
    wait_rdy(0, 40, n);
    check("t6_w_after", n > 0, 1);
    start_a(16'h010C, 16'h0, 0); tick(); a_cs = 0;
    wait_rdy(0, 40, n);
    check("t6_rd_after", s_a_rd, 16'h7E7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, width of all address buses.
REQ-002 Parameter: FIXED_PRIO, default 0; 0 = round-robin, 1 = port A always wins.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 a_Addr  in  ADDR_WIDTH  port A (CPU) address.
REQ-006 a_CS, a_L, a_U, a_WE  in  1 each  port A chip select, low-byte, high-byte and write enable.
REQ-007 a_WR  in  16  port A write data.
REQ-008 a_RD  out  16  port A read data; a_ready  out  1  done pulse; a_busy  out  1  request pending.
REQ-009 b_Addr, b_CS, b_L, b_U, b_WE, b_WR, b_RD, b_ready, b_busy: port B (chipset), same widths and meaning as port A.
REQ-010 m_Addr, m_CS, m_L, m_U, m_WE, m_WR  out  widths as port A  request to the downstream SRAM-like DDR3 wrapper.
REQ-011 m_RD  in  16, m_ready  in  1, m_busy  in  1  response from the wrapper.

Function
REQ-012 Capture: a port request SHALL be latched (Addr, L, U, WE, WR) on any edge with x_CS=1 and no request pending on that port; x_busy SHALL be 1 from the next cycle.
REQ-013 x_CS while that port is pending SHALL be ignored; the latched fields SHALL NOT change.
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT_DONE.
REQ-015 IDLE -> ISSUE when at least one port is pending and m_busy=0; the granted port's latched fields SHALL drive m_* with m_CS=1, registered, on that edge.
REQ-016 Round-robin: if both ports are pending, the port not granted last SHALL win; last-grant SHALL reset to B, so A wins the first tie.
REQ-017 FIXED_PRIO=1: A SHALL win every tie.
REQ-018 ISSUE: m_CS and all m_* SHALL hold until m_busy=1 is sampled; then m_CS, m_L, m_U and m_WE SHALL go to 0, m_Addr and m_WR to 0, and the FSM SHALL go to WAIT_DONE.
REQ-019 WAIT_DONE: on m_ready=1, the granted port SHALL get x_ready=1 for exactly one cycle and x_busy=0 in that same cycle, and the FSM SHALL go to IDLE.
REQ-020 Reads (latched WE=0): x_RD SHALL load m_RD on the m_ready edge and hold until the next completed read on that port. Writes SHALL leave x_RD unchanged.
REQ-021 The non-granted port SHALL keep its pending request and busy=1 throughout; it is granted no earlier than the IDLE cycle following the completion.
REQ-022 m_ready while in IDLE or ISSUE SHALL be ignored.
REQ-023 A port completing on edge k MAY capture a new x_CS on edge k+1 or later.
REQ-024 Minimum latency: x_CS sampled at edge k -> m_CS=1 after edge k+1 -> x_ready at edge k+3+(wrapper busy/ready delay).
REQ-025 Only one downstream transaction SHALL be outstanding at any time.

Reset
REQ-026 While i_rst=1, outputs SHALL be forced low asynchronously, independent of clk: all m_*, a_ready, b_ready, a_busy, b_busy, and a_RD = b_RD = 16'h0.
REQ-027 While i_rst=1: FSM=IDLE, both pending flags cleared, last-grant=B.
REQ-028 Reset mid-transaction SHALL drop the request and SHALL NOT produce a later x_ready; m_ready arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-029 Single A write: a_Addr=0x100, a_WR=0xBEEF, a_WE=1, L=U=1, wrapper model busy 2 cycles later, ready 5 cycles later -> m_Addr=0x100, m_WR=0xBEEF, m_CS=1 one cycle after capture; one a_ready pulse; a_RD unchanged.
REQ-030 A read after the REQ-029 write, model returning 0xBEEF -> a_RD=0xBEEF at the a_ready pulse; a_busy falls in the same cycle.
REQ-031 A and B assert CS on the same edge, 3 times -> grants ordered A, B, A, B, A, B; no overlap in m_CS; exactly 3 ready pulses per port.
REQ-032 FIXED_PRIO=1, A re-requests immediately after each completion while B is pending -> A is always granted before B; B is granted only when A is idle.
REQ-033 m_busy held 1 at reset release (calibration) with A pending -> m_CS stays 0 until m_busy=0, then issues.
REQ-034 i_rst pulsed during WAIT_DONE, then a stray m_ready -> all outputs 0; no x_ready pulse; new requests after reset are served normally.
